// File: rtl/router_pkg.sv
// Shared types and default sizing for the synchronous N-channel router control slice.
package router_pkg;

    localparam int DEF_NUM_CH  = 3;
    localparam int DEF_ADDR_W  = 2;
    localparam int DEF_TIMEOUT = 30;

    typedef enum logic [1:0] {
        CH_IDLE  = 2'd0,
        CH_COUNT = 2'd1,
        CH_FLUSH = 2'd2
    } ch_state_e;

endpackage

// File: rtl/router_ch_timer.sv
// One channel's unread-data watchdog: counts valid cycles with no read and fires
// a single-cycle soft reset at the FIFO when the channel has been abandoned too long.
//
// state    | meaning
// CH_IDLE  | FIFO empty (or just flushed); timer held at zero
// CH_COUNT | data waiting; timer counts unread cycles, a read restarts it
// CH_FLUSH | soft-reset cycle; sft_rst high for exactly this cycle
module router_ch_timer
    import router_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic vld,
    input  logic empty,
    input  logic rd_en,
    output logic sft_rst
);

    localparam int TMR_W = $clog2(TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    ch_state_e        state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             sft_rst_q, sft_rst_d;

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        sft_rst_d = 1'b0;
        case (state_q)
            CH_IDLE: begin
                timer_d = '0;
                if (vld) state_d = CH_COUNT;
            end
            CH_COUNT: begin
                // Empty wins over a read; the terminal compare stops the timer from wrapping.
                if (empty) begin
                    state_d = CH_IDLE;
                    timer_d = '0;
                end else if (rd_en) begin
                    timer_d = '0;
                end else if (timer_q == TMR_LAST) begin
                    state_d   = CH_FLUSH;
                    timer_d   = '0;
                    sft_rst_d = 1'b1;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            CH_FLUSH: begin
                state_d = CH_IDLE;
                timer_d = '0;
            end
            default: begin
                state_d = CH_IDLE;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= CH_IDLE;
            timer_q   <= '0;
            sft_rst_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            sft_rst_q <= sft_rst_d;
        end
    end

    assign sft_rst = sft_rst_q;

endmodule

// File: rtl/router_sync_nch.sv
// Router synchronizer: latches the packet destination, steers the write strobe
// to one FIFO, reports its full flag, and runs a per-channel read watchdog.
module router_sync_nch
    import router_pkg::*;
#(
    parameter int NUM_CH  = DEF_NUM_CH,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] data_in,
    input  logic              detect_add,
    input  logic              wr_en_reg,
    input  logic [NUM_CH-1:0] full,
    input  logic [NUM_CH-1:0] empty,
    input  logic [NUM_CH-1:0] rd_en,
    output logic [NUM_CH-1:0] wr_en_out,
    output logic [NUM_CH-1:0] vld_out,
    output logic [NUM_CH-1:0] sft_rst,
    output logic              fifo_full,
    output logic              addr_err
);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              addr_ok_q, addr_ok_d;
    logic              addr_err_q, addr_err_d;
    logic [NUM_CH-1:0] wr_en_q, wr_en_d;
    logic              fifo_full_q, fifo_full_d;
    logic              full_sel;
    logic              in_range;

    assign vld_out = ~empty;

    always_comb begin
        in_range   = int'(data_in) < NUM_CH;
        addr_d     = addr_q;
        addr_ok_d  = addr_ok_q;
        addr_err_d = 1'b0;
        if (detect_add) begin
            addr_d     = data_in;
            addr_ok_d  = in_range;
            addr_err_d = !in_range;
        end

        // Decode uses the address held this cycle, so a header arriving alongside
        // a write only affects the following writes.
        wr_en_d  = '0;
        full_sel = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (addr_q == ADDR_W'(i)) begin
                wr_en_d[i] = wr_en_reg & addr_ok_q;
                full_sel   = full[i];
            end
        end
        fifo_full_d = addr_ok_q & full_sel;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            addr_q      <= '1;
            addr_ok_q   <= 1'b0;
            addr_err_q  <= 1'b0;
            wr_en_q     <= '0;
            fifo_full_q <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            addr_ok_q   <= addr_ok_d;
            addr_err_q  <= addr_err_d;
            wr_en_q     <= wr_en_d;
            fifo_full_q <= fifo_full_d;
        end
    end

    assign wr_en_out = wr_en_q;
    assign fifo_full = fifo_full_q;
    assign addr_err  = addr_err_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        router_ch_timer #(
            .TIMEOUT(TIMEOUT)
        ) u_ch_timer (
            .clk    (clk),
            .rst    (rst),
            .vld    (vld_out[g]),
            .empty  (empty[g]),
            .rd_en  (rd_en[g]),
            .sft_rst(sft_rst[g])
        );
    end

endmodule

// File: tb/tb_router_sync_nch.sv
// Directed plus randomized bench for router_sync_nch against a timestamp-based
// reference model of address steering and the unread-channel watchdog.
module tb_router_sync_nch;

    localparam int NUM_CH  = 3;
    localparam int ADDR_W  = 2;
    localparam int TIMEOUT = 30;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] data_in;
    logic              detect_add;
    logic              wr_en_reg;
    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] empty;
    logic [NUM_CH-1:0] rd_en;
    logic [NUM_CH-1:0] wr_en_out;
    logic [NUM_CH-1:0] vld_out;
    logic [NUM_CH-1:0] sft_rst;
    logic              fifo_full;
    logic              addr_err;

    router_sync_nch #(
        .NUM_CH (NUM_CH),
        .ADDR_W (ADDR_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .detect_add(detect_add),
        .wr_en_reg (wr_en_reg),
        .full      (full),
        .empty     (empty),
        .rd_en     (rd_en),
        .wr_en_out (wr_en_out),
        .vld_out   (vld_out),
        .sft_rst   (sft_rst),
        .fifo_full (fifo_full),
        .addr_err  (addr_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit known    = 1'b0;

    // Model: a channel's watchdog fires TIMEOUT+1 cycles after the cycle that
    // began its current unread streak (-1 = no streak in progress).
    int                start_cyc [NUM_CH];
    int                m_addr;
    bit                m_ok;
    logic [NUM_CH-1:0] exp_wr;
    logic              exp_full;
    logic              exp_err;
    logic [NUM_CH-1:0] exp_sft;

    task automatic step(input logic r, input logic det, input logic [ADDR_W-1:0] din,
                        input logic wr, input logic [NUM_CH-1:0] fl,
                        input logic [NUM_CH-1:0] em, input logic [NUM_CH-1:0] rd);
        rst = r; detect_add = det; data_in = din; wr_en_reg = wr;
        full = fl; empty = em; rd_en = rd;
        #1;
        for (int c = 0; c < NUM_CH; c++)
            exp_sft[c] = (start_cyc[c] >= 0) && (cyc == start_cyc[c] + TIMEOUT + 1);

        checks++;
        assert (vld_out === ~em) else begin
            failures++;
            $error("FAIL vld_out cyc=%0d got=%b exp=%b", cyc, vld_out, ~em);
        end
        if (known) begin
            checks++;
            assert (wr_en_out === exp_wr) else begin
                failures++;
                $error("FAIL wr_en_out cyc=%0d got=%b exp=%b", cyc, wr_en_out, exp_wr);
            end
            checks++;
            assert (fifo_full === exp_full) else begin
                failures++;
                $error("FAIL fifo_full cyc=%0d got=%b exp=%b", cyc, fifo_full, exp_full);
            end
            checks++;
            assert (addr_err === exp_err) else begin
                failures++;
                $error("FAIL addr_err cyc=%0d got=%b exp=%b", cyc, addr_err, exp_err);
            end
            checks++;
            assert (sft_rst === exp_sft) else begin
                failures++;
                $error("FAIL sft_rst cyc=%0d got=%b exp=%b", cyc, sft_rst, exp_sft);
            end
        end

        if (!r) begin
            for (int c = 0; c < NUM_CH; c++) start_cyc[c] = -1;
            m_addr = (1 << ADDR_W) - 1;
            m_ok = 1'b0;
            exp_wr = '0;
            exp_full = 1'b0;
            exp_err = 1'b0;
            known = 1'b1;
        end else begin
            exp_wr   = (wr && m_ok) ? NUM_CH'(1 << m_addr) : '0;
            exp_full = m_ok ? fl[m_addr] : 1'b0;
            exp_err  = det && (int'(din) >= NUM_CH);
            if (det) begin
                m_addr = int'(din);
                m_ok   = int'(din) < NUM_CH;
            end
            for (int c = 0; c < NUM_CH; c++) begin
                if (exp_sft[c] || em[c]) start_cyc[c] = -1;
                else if (start_cyc[c] < 0 || rd[c]) start_cyc[c] = cyc;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    logic [NUM_CH-1:0] em_r;
    logic [NUM_CH-1:0] rd_r;

    initial begin
        for (int c = 0; c < NUM_CH; c++) start_cyc[c] = -1;
        m_addr = 3; m_ok = 1'b0;
        exp_wr = '0; exp_full = 1'b0; exp_err = 1'b0; exp_sft = '0;
        @(negedge clk);

        // Reset, then observe the reset state.
        step(0, 0, 2'd0, 0, 3'b000, 3'b111, 3'b000);
        step(0, 1, 2'd1, 1, 3'b111, 3'b111, 3'b000);
        step(1, 0, 2'd0, 1, 3'b111, 3'b111, 3'b000);
        step(1, 0, 2'd0, 0, 3'b000, 3'b111, 3'b000);

        // In-range header to FIFO 2, then a write.
        step(1, 1, 2'd2, 0, 3'b000, 3'b111, 3'b000);
        step(1, 0, 2'd0, 1, 3'b100, 3'b111, 3'b000);
        step(1, 0, 2'd0, 0, 3'b011, 3'b111, 3'b000);
        step(1, 0, 2'd0, 0, 3'b000, 3'b111, 3'b000);

        // Header and write in the same cycle: write still goes to the old address.
        step(1, 1, 2'd0, 1, 3'b001, 3'b111, 3'b000);
        step(1, 0, 2'd0, 1, 3'b001, 3'b111, 3'b000);
        step(1, 0, 2'd0, 0, 3'b000, 3'b111, 3'b000);

        // Out-of-range header: error pulse, writes and full suppressed.
        step(1, 1, 2'd3, 0, 3'b111, 3'b111, 3'b000);
        step(1, 0, 2'd0, 1, 3'b111, 3'b111, 3'b000);
        step(1, 0, 2'd0, 1, 3'b111, 3'b111, 3'b000);
        step(1, 0, 2'd0, 0, 3'b000, 3'b111, 3'b000);

        // Channel 1 valid, never read: periodic soft resets.
        for (int k = 0; k < 70; k++) step(1, 0, 2'd0, 0, 3'b000, 3'b101, 3'b000);
        for (int k = 0; k < 3; k++)  step(1, 0, 2'd0, 0, 3'b000, 3'b111, 3'b000);

        // Channel 1 read once at cycle 20, then left unread.
        for (int k = 0; k < 60; k++)
            step(1, 0, 2'd0, 0, 3'b000, 3'b101, (k == 20) ? 3'b010 : 3'b000);
        for (int k = 0; k < 3; k++)  step(1, 0, 2'd0, 0, 3'b000, 3'b111, 3'b000);

        // Channels 0 and 2 time out together.
        for (int k = 0; k < 34; k++) step(1, 0, 2'd0, 0, 3'b000, 3'b010, 3'b000);
        for (int k = 0; k < 3; k++)  step(1, 0, 2'd0, 0, 3'b000, 3'b111, 3'b000);

        // Reset lands exactly where the timer reached its terminal count.
        step(1, 1, 2'd1, 0, 3'b010, 3'b111, 3'b000);
        for (int k = 0; k < 30; k++) step(1, 0, 2'd0, 1, 3'b010, 3'b101, 3'b000);
        step(0, 0, 2'd0, 1, 3'b010, 3'b101, 3'b000);
        for (int k = 0; k < 35; k++) step(1, 0, 2'd0, 0, 3'b000, 3'b111, 3'b000);

        // Randomized traffic.
        em_r = 3'b111;
        for (int k = 0; k < 3000; k++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if ($urandom_range(0, 49) == 0) em_r[c] = ~em_r[c];
                rd_r[c] = ($urandom_range(0, 39) == 0);
            end
            step(($urandom_range(0, 299) != 0),
                 ($urandom_range(0, 5) == 0),
                 ADDR_W'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)),
                 NUM_CH'($urandom_range(0, 7)),
                 em_r, rd_r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
